cpu_run_controller: RTL and testbench
=====================================

# cpu_run_controller

Run/step/halt sequencer for the single-cycle MIPS CPU on the BASYS3 board. It debounces the three board push-buttons and generates the CPU-wide clock enable in three modes: free-running with an optional rate divider, single-instruction step, and automatic halt when the PC reaches the end-of-program address. It also steps the data-memory display address shown on the seven-segment driver. It sits between the board buttons and the CPU core, replacing the ad-hoc clock FSM and the button-clocked display counter.

## Interface

Parameters:
- DEBOUNCE_CYCLES, default 1000000: consecutive stable synchronized samples required to accept a button level change.
- RUN_DIV, default 1: in RUN, clk_en fires once every RUN_DIV cycles. Legal range 1 to 2^24-1.
- HALT_PC, default 8'h40: PC[7:0] value at which execution stops.
- DISP_DEPTH, default 8: number of display words; display address wraps at this value.

Ports:
- clk, in, 1: system clock, 100 MHz. One clock; reset is asynchronous and active-low.
- rst_n, in, 1: asynchronous active-low reset.
- btn_run_i, in, 1: raw centre button. Toggles between run and pause.
- btn_step_i, in, 1: raw step button. Executes one instruction while paused.
- btn_disp_i, in, 1: raw left button. Advances the display address.
- pc_i, in, 8: current PC[7:0] from the core.
- clk_en_o, out, 1: CPU clock enable for the PC, register file and data memory.
- finished_o, out, 1: high while in HALT.
- disp_addr_o, out, clog2(DISP_DEPTH): data-memory display read address.
- state_o, out, 2: current state (IDLE=0, RUN=1, STEP=2, HALT=3).

## Operation

- Each button goes through a 2-flop synchronizer and then a stability counter. The debounced level flips only after DEBOUNCE_CYCLES consecutive synchronized samples that differ from the current level; any sample equal to the current level resets the count.
- A rising edge of the debounced level produces a one-cycle press pulse. Release produces no pulse.
- FSM:
  - IDLE: run press goes to RUN, which clears the divider. Step press goes to STEP. Simultaneous run and step press: run wins.
  - RUN: run press goes to IDLE. pc_i == HALT_PC goes to HALT. Step presses are ignored.
  - STEP: lasts exactly one cycle, then goes to IDLE, or to HALT if pc_i == HALT_PC.
  - HALT: absorbing. All presses except display are ignored. Only rst_n leaves HALT.
- Halt check has priority over a run press in the same cycle.
- Divider: counts 0 to RUN_DIV-1 only in RUN. tick = (count == RUN_DIV-1). Count wraps on tick and holds at 0 outside RUN. RUN_DIV=1 gives tick every cycle.
- clk_en_o is combinational: ((state==RUN && tick) || state==STEP) && pc_i != HALT_PC. The CPU therefore never executes the instruction at HALT_PC.
- finished_o = (state==HALT).
- Display press increments disp_addr_o modulo DISP_DEPTH in every state, including HALT. DISP_DEPTH-1 wraps to 0.

## Timing

- Reset values: state IDLE, clk_en_o 0, finished_o 0, disp_addr_o 0, divider 0, synchronizers and debounced levels 0, stability counters 0.
- Press latency: a raw rising edge held stable produces its pulse exactly DEBOUNCE_CYCLES+2 cycles after the first clk edge that samples it high.
- Pulse to state change: 1 cycle, with the state register updating on the edge after the pulse.
- In RUN with RUN_DIV=N, clk_en_o is high on cycles N-1, 2N-1, ... counted from RUN entry, with entry as cycle 0.
- STEP yields exactly one clk_en_o cycle.
- Run press in RUN at the same cycle as tick: clk_en_o is still high that cycle, and state is IDLE from the next cycle.
- Asserting rst_n mid-run forces clk_en_o low immediately (asynchronously); no instruction completes after that.

## Structure

- Shared package cpu_ctrl_pkg holds:
  - the state enum and its encodings;
  - HALT_PC_DEFAULT and DEBOUNCE_CYCLES_DEFAULT.
- Sub-module button_debounce (synchronizer, stability counter, press pulse) is instantiated three times.
- The FSM, divider and display counter live in cpu_run_controller.

## Test plan

Bench uses DEBOUNCE_CYCLES=4, RUN_DIV=3.

- Reset, then hold btn_run_i high 10 cycles: pulse on cycle 6, state_o=1 on cycle 7, clk_en_o high on cycles 9, 12, 15 relative to the raw edge.
- Bounce btn_step_i 1-0-1-0 at 1-cycle spacing, then hold high: exactly one press, STEP for one cycle, exactly one clk_en_o cycle, back to IDLE.
- In RUN, drive pc_i=8'h40: clk_en_o low in the same cycle, state_o=3 and finished_o=1 next cycle. Later run and step presses leave it unchanged.
- Nine display presses: disp_addr_o goes 1..7, 0, 1. It also advances while in HALT.
- Simultaneous run and step press in IDLE: state goes to RUN. Pulse rst_n low mid-RUN: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and defaults for the CPU run/step/halt controller.
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2,
      ST_HALT = 2'd3
   } state_e;

   localparam logic [7:0] HALT_PC_DEFAULT = 8'h40;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
   localparam int RUN_DIV_WIDTH = 24;

endpackage

// File: rtl/cpu_run_controller_if.sv
// Board-button / CPU-core side signals of the run controller.
interface cpu_run_controller_if #(
   parameter int DISP_DEPTH = 8
);
   localparam int AW = $clog2(DISP_DEPTH);

   logic          btn_run_i;
   logic          btn_step_i;
   logic          btn_disp_i;
   logic [7:0]    pc_i;
   logic          clk_en_o;
   logic          finished_o;
   logic [AW-1:0] disp_addr_o;
   logic [1:0]    state_o;

   modport master (
      output btn_run_i, btn_step_i, btn_disp_i, pc_i,
      input  clk_en_o, finished_o, disp_addr_o, state_o
   );

   modport slave (
      input  btn_run_i, btn_step_i, btn_disp_i, pc_i,
      output clk_en_o, finished_o, disp_addr_o, state_o
   );

endinterface

// File: rtl/button_debounce.sv
// Push-button synchronizer, stability debouncer and press pulse.
module button_debounce
   import cpu_ctrl_pkg::*;
#(
   parameter int CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press
);

   localparam int CW = $clog2(CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic          level_q;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

   // Any sample matching the current level restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (sync2 == level) begin
         cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
         cnt   <= '0;
         level <= sync2;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= 1'b0;
         press   <= 1'b0;
      end else begin
         level_q <= level;
         press   <= level & ~level_q;
      end
   end

endmodule

// File: rtl/cpu_run_controller.sv
// Run/step/halt sequencer producing the CPU clock enable and display address.
module cpu_run_controller
   import cpu_ctrl_pkg::*;
#(
   parameter int         DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int         RUN_DIV         = 1,
   parameter logic [7:0] HALT_PC         = HALT_PC_DEFAULT,
   parameter int         DISP_DEPTH      = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   cpu_run_controller_if.slave bus
);

   localparam int AW = $clog2(DISP_DEPTH);
   localparam int DW = RUN_DIV_WIDTH;

   state_e        state_q;
   state_e        state_d;
   logic [DW-1:0] div_q;
   logic [DW-1:0] div_d;
   logic [AW-1:0] disp_q;
   logic          run_p;
   logic          step_p;
   logic          disp_p;
   logic          tick;
   logic          at_halt;

   button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_run (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (bus.btn_run_i),
      .press (run_p)
   );

   button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_step (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (bus.btn_step_i),
      .press (step_p)
   );

   button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_disp (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (bus.btn_disp_i),
      .press (disp_p)
   );

   assign at_halt = (bus.pc_i == HALT_PC);
   assign tick    = (div_q == DW'(RUN_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (run_p)
               state_d = ST_RUN;
            else if (step_p)
               state_d = ST_STEP;
         end
         ST_RUN: begin
            if (at_halt)
               state_d = ST_HALT;
            else if (run_p)
               state_d = ST_IDLE;
         end
         ST_STEP: begin
            state_d = at_halt ? ST_HALT : ST_IDLE;
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
      endcase
      // Divider only advances while staying in RUN; entry starts at 0.
      if (state_q == ST_RUN && state_d == ST_RUN)
         div_d = tick ? '0 : div_q + DW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         disp_q <= '0;
      else if (disp_p)
         disp_q <= (disp_q == AW'(DISP_DEPTH - 1)) ? '0 : disp_q + AW'(1);
   end

   assign bus.clk_en_o    = ((state_q == ST_RUN && tick) ||
                             state_q == ST_STEP) && !at_halt;
   assign bus.finished_o  = (state_q == ST_HALT);
   assign bus.disp_addr_o = disp_q;
   assign bus.state_o     = state_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed scoreboard bench for the CPU run controller.
module tb_cpu_run_controller;

   typedef struct {
      string      tag;
      logic [7:0] val;
   } sb_t;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;
   sb_t  sb[$];

   cpu_run_controller_if #(.DISP_DEPTH(8)) bus ();

   cpu_run_controller #(
      .DEBOUNCE_CYCLES (4),
      .RUN_DIV         (3),
      .HALT_PC         (8'h40),
      .DISP_DEPTH      (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic nxt();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [7:0] mk(input logic ce, input logic fin,
                                     input logic [1:0] st, input logic p,
                                     input logic [2:0] d);
      return {ce, fin, st, p, d};
   endfunction

   function automatic logic [7:0] obs(input logic p);
      return {bus.clk_en_o, bus.finished_o, bus.state_o, p, bus.disp_addr_o};
   endfunction

   task automatic push(input string tag, input logic [7:0] v);
      sb.push_back('{tag, v});
   endtask

   task automatic chk(input logic [7:0] o);
      sb_t e;
      n_chk++;
      if (sb.size() == 0) begin
         n_err++;
         $error("FAIL sb_empty observed=%0h expected=none", o);
      end else begin
         e = sb.pop_front();
         assert (o === e.val) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
         end
      end
   endtask

   task automatic press_disp(input logic [2:0] d, input logic fin,
                             input logic [1:0] st);
      bus.btn_disp_i = 1'b1;
      push($sformatf("disp_%0d", d), mk(1'b0, fin, st, 1'b0, d));
      repeat (8) nxt();
      bus.btn_disp_i = 1'b0;
      repeat (10) nxt();
      chk(obs(1'b0));
   endtask

   initial begin
      clk   = 1'b0;
      rst_n = 1'b0;
      n_chk = 0;
      n_err = 0;
      bus.btn_run_i  = 1'b0;
      bus.btn_step_i = 1'b0;
      bus.btn_disp_i = 1'b0;
      bus.pc_i       = 8'h00;

      // reset state
      repeat (2) nxt();
      push("rst_hold", mk(0, 0, 2'd0, 0, 3'd0));
      chk(obs(dut.run_p));
      rst_n = 1'b1;
      repeat (2) nxt();
      push("rst_rel", mk(0, 0, 2'd0, 0, 3'd0));
      chk(obs(dut.run_p));

      // run press: pulse c6, RUN c7, clk_en c9/c12/c15
      bus.btn_run_i = 1'b1;
      for (int i = 0; i < 16; i++)
         push($sformatf("run_c%0d", i),
              mk(i == 9 || i == 12 || i == 15, 0,
                 (i >= 7) ? 2'd1 : 2'd0, i == 6, 3'd0));
      for (int i = 0; i < 16; i++) begin
         nxt();
         chk(obs(dut.run_p));
         if (i == 9) bus.btn_run_i = 1'b0;
      end
      repeat (4) nxt();

      // pause press returns to IDLE
      bus.btn_run_i = 1'b1;
      for (int i = 0; i < 10; i++)
         push($sformatf("pause_c%0d", i), (i >= 7) ? 8'd0 : 8'd1);
      for (int i = 0; i < 10; i++) begin
         nxt();
         chk({6'd0, bus.state_o});
      end
      bus.btn_run_i = 1'b0;
      repeat (10) nxt();

      // bounced step: one pulse, one STEP cycle, one clk_en
      bus.btn_step_i = 1'b1;
      for (int i = 0; i < 17; i++)
         push($sformatf("step_c%0d", i),
              mk(i == 11, 0, (i == 11) ? 2'd2 : 2'd0, i == 10, 3'd0));
      for (int i = 0; i < 17; i++) begin
         nxt();
         chk(obs(dut.step_p));
         if (i == 0) bus.btn_step_i = 1'b0;
         if (i == 1) bus.btn_step_i = 1'b1;
         if (i == 2) bus.btn_step_i = 1'b0;
         if (i == 3) bus.btn_step_i = 1'b1;
         if (i == 13) bus.btn_step_i = 1'b0;
      end
      repeat (10) nxt();

      // display: first press with exact latency, then six more
      bus.btn_disp_i = 1'b1;
      for (int i = 0; i < 8; i++)
         push($sformatf("disp1_c%0d", i), (i >= 7) ? 8'd1 : 8'd0);
      for (int i = 0; i < 8; i++) begin
         nxt();
         chk({5'd0, bus.disp_addr_o});
      end
      bus.btn_disp_i = 1'b0;
      repeat (10) nxt();
      for (int k = 2; k < 8; k++)
         press_disp(3'(k), 1'b0, 2'd0);

      // RUN then halt address
      bus.btn_run_i = 1'b1;
      for (int i = 0; i < 10; i++)
         push($sformatf("run2_c%0d", i),
              mk(i == 9, 0, (i >= 7) ? 2'd1 : 2'd0, i == 6, 3'd7));
      for (int i = 0; i < 10; i++) begin
         nxt();
         chk(obs(dut.run_p));
      end
      bus.btn_run_i = 1'b0;
      bus.pc_i = 8'h40;
      #1;
      push("halt_same", mk(0, 0, 2'd1, 0, 3'd7));
      chk(obs(dut.run_p));
      nxt();
      push("halt_next", mk(0, 1, 2'd3, 0, 3'd7));
      chk(obs(dut.run_p));
      repeat (10) nxt();

      // presses ignored in HALT, display still advances
      bus.btn_run_i  = 1'b1;
      bus.btn_step_i = 1'b1;
      push("halt_press", mk(0, 1, 2'd3, 0, 3'd7));
      repeat (10) nxt();
      chk(obs(1'b0));
      bus.btn_run_i  = 1'b0;
      bus.btn_step_i = 1'b0;
      repeat (10) nxt();
      press_disp(3'd0, 1'b1, 2'd3);
      press_disp(3'd1, 1'b1, 2'd3);

      // asynchronous reset out of HALT
      rst_n = 1'b0;
      #1;
      push("rst_halt", mk(0, 0, 2'd0, 0, 3'd0));
      chk(obs(dut.run_p));
      bus.pc_i = 8'h00;
      repeat (2) nxt();
      rst_n = 1'b1;
      repeat (2) nxt();

      // simultaneous run+step: run wins
      bus.btn_run_i  = 1'b1;
      bus.btn_step_i = 1'b1;
      for (int i = 0; i < 10; i++)
         push($sformatf("both_c%0d", i),
              mk(i == 9, 0, (i >= 7) ? 2'd1 : 2'd0, i == 6, 3'd0));
      for (int i = 0; i < 10; i++) begin
         nxt();
         chk(obs(dut.step_p));
      end

      // mid-RUN reset drops clk_en at once
      rst_n = 1'b0;
      #1;
      push("rst_async", mk(0, 0, 2'd0, 0, 3'd0));
      chk(obs(dut.run_p));
      bus.btn_run_i  = 1'b0;
      bus.btn_step_i = 1'b0;
      nxt();
      rst_n = 1'b1;
      nxt();

      if (sb.size() != 0) begin
         n_err++;
         $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
